// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the instruction and data caches.
// Round-robin on ties, owner-only ack routing, and a watchdog for a silent memory.
module mem_bus_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int MEMBUS_SIZE = 256,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mreq,
    input  logic [WORD_SIZE-1:0]   i_maddr,
    output logic                   i_ack_n,
    output logic [MEMBUS_SIZE-1:0] i_rdata,
    input  logic                   d_mreq,
    input  logic                   d_mwrite,
    input  logic [WORD_SIZE-1:0]   d_maddr,
    input  logic [MEMBUS_SIZE-1:0] d_wdata,
    output logic                   d_ack_n,
    output logic [MEMBUS_SIZE-1:0] d_rdata,
    output logic                   m_req,
    output logic                   m_write,
    output logic [WORD_SIZE-1:0]   m_addr,
    output logic [MEMBUS_SIZE-1:0] m_wdata,
    input  logic [MEMBUS_SIZE-1:0] m_rdata,
    input  logic                   m_ack_n,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    localparam int WDOG_W = $clog2(TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1 = last grant went to the dcache
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;

    logic own_d;
    logic own_mreq;
    logic oth_mreq;

    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        m_req         = 1'b0;
        m_write       = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        i_ack_n       = 1'b1;
        d_ack_n       = 1'b1;
        own_d         = (state_q == ST_GRANT_D);
        own_mreq      = own_d ? d_mreq : i_mreq;
        oth_mreq      = own_d ? i_mreq : d_mreq;

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                // On a tie the side that did not win last time gets the port.
                if (i_mreq && (!d_mreq || last_d_q)) begin
                    state_d  = ST_GRANT_I;
                    last_d_d = 1'b0;
                end else if (d_mreq) begin
                    state_d  = ST_GRANT_D;
                    last_d_d = 1'b1;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                m_req   = own_mreq;
                m_addr  = own_d ? d_maddr : i_maddr;
                m_write = own_d & d_mwrite;
                m_wdata = own_d ? d_wdata : '0;
                if (!m_ack_n) begin
                    // Ack beats a same-cycle drop or watchdog expiry.
                    i_ack_n = own_d;
                    d_ack_n = !own_d;
                    wdog_d  = '0;
                    if (oth_mreq) begin
                        state_d  = own_d ? ST_GRANT_I : ST_GRANT_D;
                        last_d_d = !own_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!own_mreq) begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    wdog_d        = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_d_q      <= 1'b0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign i_rdata     = m_rdata;
    assign d_rdata     = m_rdata;
    assign timeout_err = timeout_err_q;

endmodule
